// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid_reg
//  Description : Generic pipeline-stage register with a 2-entry skid buffer.
//                Carries a datapath and a control bundle under valid/ready.
//                in_ready comes straight from a flop, so the upstream stall
//                path has no combinational dependency on out_ready.
//                Vacated slots are zeroed so a bubble always presents
//                all-zero control. Includes saturating stall/flush counters.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_skid_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  state_t              r_state;
  logic                r_in_ready;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  logic w_out_valid;
  logic w_accept;
  logic w_drain;
  logic w_stall;
  logic w_flush_hit;

  // Handshake qualifiers; the main slot is always the head of the queue.
  assign w_out_valid = (r_state != S_EMPTY);
  assign w_accept    = in_valid & r_in_ready & ~flush;
  assign w_drain     = w_out_valid & out_ready;
  assign w_stall     = w_out_valid & ~out_ready & ~flush;
  assign w_flush_hit = flush & (r_state != S_EMPTY);

  // Occupancy FSM: owns both slots and the registered in_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b0;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (flush) begin
      // Squash everything held; in_valid is ignored this cycle.
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      // in_ready tracks "next state is not FULL"; cleared below where needed.
      r_in_ready <= 1'b1;
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_accept) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
            r_state     <= S_FULL;
            r_in_ready  <= 1'b0;
          end else if (w_drain) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_state     <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_drain) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
            r_state     <= S_ONE;
          end else begin
            r_in_ready  <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_main_data <= '0;
          r_main_ctrl <= '0;
          r_skid_data <= '0;
          r_skid_ctrl <= '0;
        end
      endcase
    end
  end

  // Saturating count of downstream backpressure cycles (not during flush).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Saturating count of flushes that actually discarded a valid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= '0;
    end else if (w_flush_hit && (r_flush_cnt != c_CNT_MAX)) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_ctrl;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_skid_reg
//  Description : Directed self-checking bench for pipe_stage_skid_reg.
//                Inputs change and outputs are observed 1 time unit after
//                each rising clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 128;
  localparam int CTRL_W = 9;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int n_pass;
  int n_total;

  localparam logic [DATA_W-1:0] c_A = {4{32'hA5A5_0001}};
  localparam logic [DATA_W-1:0] c_B = {4{32'h5B5B_0002}};
  localparam logic [DATA_W-1:0] c_C = {4{32'hC3C3_0003}};
  localparam logic [DATA_W-1:0] c_D = {4{32'hD4D4_0004}};
  localparam logic [CTRL_W-1:0] c_CA = 9'h0A5;
  localparam logic [CTRL_W-1:0] c_CB = 9'h15A;
  localparam logic [CTRL_W-1:0] c_CC = 9'h1FF;
  localparam logic [CTRL_W-1:0] c_CD = 9'h123;

  pipe_stage_skid_reg #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    tick(); tick();
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready_low got %0b want 0", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b want 0", out_valid); else n_pass++;
    n_total++; if (out_ctrl !== '0) $display("FAIL rst_out_ctrl got %h want 0", out_ctrl); else n_pass++;
    n_total++; if (stall_cnt !== '0 || flush_cnt !== '0) $display("FAIL rst_counters got %0d/%0d want 0/0", stall_cnt, flush_cnt); else n_pass++;
    rst = 1'b0;
    tick();
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %0b want 1", in_ready); else n_pass++;
    // Fill to FULL, then hit reset asynchronously mid-cycle.
    in_valid = 1'b1; in_data = c_A; in_ctrl = c_CA;
    tick();
    in_data = c_B; in_ctrl = c_CB;
    tick();
    in_valid = 1'b0;
    n_total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL rst_prefill_full got rdy=%0b vld=%0b want 0/1", in_ready, out_valid); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_async_valid got %0b want 0", out_valid); else n_pass++;
    n_total++; if (out_ctrl !== '0 || out_data !== '0) $display("FAIL rst_async_bundle got ctrl=%h data=%h want 0", out_ctrl, out_data); else n_pass++;
    n_total++; if (stall_cnt !== '0) $display("FAIL rst_async_stall got %0d want 0", stall_cnt); else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL rst_after_release got rdy=%0b vld=%0b want 1/0", in_ready, out_valid); else n_pass++;
  endtask

  task automatic test_streaming();
    int gaps;
    gaps = 0;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(i);
      in_ctrl  = CTRL_W'(i * 3);
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b1) gaps++;
      n_total++; if (out_data !== DATA_W'(i) || out_ctrl !== CTRL_W'(i * 3)) $display("FAIL stream_item%0d got data=%0h ctrl=%h want %0h/%h", i, out_data, out_ctrl, i, i * 3); else n_pass++;
    end
    n_total++; if (gaps != 0) $display("FAIL stream_gaps got %0d want 0", gaps); else n_pass++;
    in_valid = 1'b0;
    tick();
    n_total++; if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) $display("FAIL stream_drained got vld=%0b ctrl=%h data=%h want 0", out_valid, out_ctrl, out_data); else n_pass++;
    n_total++; if (stall_cnt !== 4'd0) $display("FAIL stream_stall got %0d want 0", stall_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = c_A; in_ctrl = c_CA;
    tick();
    in_data = c_B; in_ctrl = c_CB;
    tick();
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready got %0b want 0", in_ready); else n_pass++;
    n_total++; if (out_data !== c_A || out_ctrl !== c_CA) $display("FAIL bp_head got data=%h ctrl=%h want A", out_data, out_ctrl); else n_pass++;
    // D is offered while in_ready=0 and must never appear.
    in_data = c_D; in_ctrl = c_CD;
    tick();
    n_total++; if (out_data !== c_A || in_ready !== 1'b0) $display("FAIL bp_hold got data=%h rdy=%0b want A/0", out_data, in_ready); else n_pass++;
    n_total++; if (stall_cnt !== 4'd2) $display("FAIL bp_stall got %0d want 2", stall_cnt); else n_pass++;
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_total++; if (out_valid !== 1'b1 || out_data !== c_B || out_ctrl !== c_CB) $display("FAIL bp_second got vld=%0b data=%h ctrl=%h want B", out_valid, out_data, out_ctrl); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back got %0b want 1", in_ready); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0 || out_ctrl !== '0) $display("FAIL bp_empty got vld=%0b ctrl=%h want 0", out_valid, out_ctrl); else n_pass++;
    n_total++; if (stall_cnt !== 4'd2) $display("FAIL bp_stall_final got %0d want 2", stall_cnt); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_flush_full();
    in_valid = 1'b1; in_data = c_A; in_ctrl = c_CA;
    tick();
    in_data = c_B; in_ctrl = c_CB;
    tick();
    // stall_cnt is now 3 (one stalled edge while holding A).
    flush = 1'b1; in_valid = 1'b1; in_data = c_C; in_ctrl = c_CC;
    tick();
    n_total++; if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) $display("FAIL flfull_empty got vld=%0b ctrl=%h data=%h want 0", out_valid, out_ctrl, out_data); else n_pass++;
    n_total++; if (flush_cnt !== 4'd1) $display("FAIL flfull_cnt got %0d want 1", flush_cnt); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL flfull_ready got %0b want 1", in_ready); else n_pass++;
    n_total++; if (stall_cnt !== 4'd3) $display("FAIL flfull_stall got %0d want 3", stall_cnt); else n_pass++;
    flush = 1'b0; in_valid = 1'b0;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL flfull_c_dropped got vld=%0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_flush_empty();
    flush = 1'b1;
    tick();
    n_total++; if (flush_cnt !== 4'd1) $display("FAIL flempty_cnt got %0d want 1", flush_cnt); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL flempty_ready got %0b want 1", in_ready); else n_pass++;
    flush = 1'b0;
    // Flush coinciding with a drain from ONE still counts and empties.
    in_valid = 1'b1; in_data = c_D; in_ctrl = c_CD;
    tick();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    tick();
    n_total++; if (flush_cnt !== 4'd2 || out_valid !== 1'b0) $display("FAIL flone_drain got cnt=%0d vld=%0b want 2/0", flush_cnt, out_valid); else n_pass++;
    flush = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    in_valid = 1'b1; in_data = c_C; in_ctrl = c_CC;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_total++; if (stall_cnt !== 4'd15) $display("FAIL sat_stall got %0d want 15", stall_cnt); else n_pass++;
    n_total++; if (out_valid !== 1'b1 || out_data !== c_C) $display("FAIL sat_head got vld=%0b data=%h want C", out_valid, out_data); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_total++; if (out_valid !== 1'b0 || stall_cnt !== 4'd15) $display("FAIL sat_drain got vld=%0b stall=%0d want 0/15", out_valid, stall_cnt); else n_pass++;
    out_ready = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_flush_empty();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Runaway guard.
  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
